// File: rtl/uart_pkg.sv
// Shared UART types and defaults: receiver FSM states, parity encodings and
// a 2-of-3 majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_PRESCALE_WIDTH = 6;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: per-bit edge counter, bit counter and a
// three-sample majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      rx_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o,
    output logic                      sampled_bit_o,
    output logic                      bit_strobe_o,
    output logic                      bit_end_o
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WIDTH-1:0] half, last;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]                samples_q, samples_d;
    logic                      strobe_q, strobe_d;
    logic                      in_window;

    assign half      = prescale_i >> 1;
    assign last      = prescale_i - PRESCALE_WIDTH'(1);
    assign in_window = (edge_cnt_q >= half - PRESCALE_WIDTH'(2)) && (edge_cnt_q <= half);
    assign bit_end_o = en_i && (edge_cnt_q == last);

    // The vote is presented the cycle after the last sample has been captured.
    assign bit_strobe_o  = strobe_q;
    assign sampled_bit_o = majority3(samples_q);
    assign bit_cnt_o     = bit_cnt_q;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samples_d  = samples_q;
        strobe_d   = 1'b0;
        if (!en_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            if (bit_end_o) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_CNT_WIDTH'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
            end
            strobe_d = (edge_cnt_q == half);
            if (in_window) begin
                samples_d = {samples_q[1:0], rx_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samples_q  <= '0;
            strobe_q   <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samples_q  <= samples_d;
            strobe_q   <= strobe_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises RX_IN, detects the start edge, walks the frame
// with an FSM and reports the byte or its parity/stop errors as one-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);

    localparam int BCW = $clog2(DATA_WIDTH + 3);
    localparam logic [BCW-1:0] LAST_DATA_BIT = BCW'(DATA_WIDTH);

    rx_state_e                 state_q, state_d;
    logic                      rx_meta_q, rx_s_q, rx_prev_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q, par_typ_q;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      par_fail_q, par_fail_d;
    logic                      dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic                      cfg_load, start_edge, exp_par;
    logic [BCW-1:0]            bit_cnt;
    logic                      sampled_bit, bit_strobe, bit_end;

    assign start_edge = rx_prev_q & ~rx_s_q;
    assign exp_par    = (^shift_q) ^ (par_typ_q == PAR_ODD);

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BCW)
    ) u_sampler (
        .clk_i         (CLK),
        .rst_i         (RST),
        .en_i          (state_q != IDLE),
        .rx_i          (rx_s_q),
        .prescale_i    (prescale_q),
        .bit_cnt_o     (bit_cnt),
        .sampled_bit_o (sampled_bit),
        .bit_strobe_o  (bit_strobe),
        .bit_end_o     (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        par_fail_d = par_fail_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        cfg_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d    = START;
                    cfg_load   = 1'b1;
                    par_fail_d = 1'b0;
                end
            end
            START: begin
                if (bit_strobe) begin
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                end
                if (bit_end && bit_cnt == LAST_DATA_BIT) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_strobe && sampled_bit != exp_par) begin
                    par_fail_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Decide at the stop-bit centre so a following start edge is not missed.
                if (bit_strobe) begin
                    state_d = IDLE;
                    pe_d    = par_fail_q;
                    se_d    = ~sampled_bit;
                    if (sampled_bit && !par_fail_q) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            shift_q    <= '0;
            p_data_q   <= '0;
            par_fail_q <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= RX_IN;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            par_fail_q <= par_fail_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            if (cfg_load) begin
                prescale_q <= PRESCALE;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised from a line-level model,
// expected pulses are queued with their due cycle and a monitor checks them.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID, PAR_ERR, STP_ERR;

    uart_rx #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model_pdata = 8'h00;
    int         tests = 0;
    int         fails = 0;

    // Monitor: every output pulse must match the oldest expectation, on time.
    always @(negedge CLK) begin
        if (!RST) begin
            if (DATA_VALID || PAR_ERR || STP_ERR) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: got dv/pe/se=%b%b%b p_data=%h at cyc %0d, required no pulse",
                             DATA_VALID, PAR_ERR, STP_ERR, P_DATA, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (DATA_VALID !== mon_e.dv || PAR_ERR !== mon_e.pe || STP_ERR !== mon_e.se ||
                        P_DATA !== mon_e.data || cyc != mon_e.at) begin
                        fails++;
                        $display("FAIL frame_result: got dv/pe/se=%b%b%b p_data=%h cyc=%0d, required %b%b%b p_data=%h cyc=%0d",
                                 DATA_VALID, PAR_ERR, STP_ERR, P_DATA, cyc,
                                 mon_e.dv, mon_e.pe, mon_e.se, mon_e.data, mon_e.at);
                    end else begin
                        $display("[TB] frame ok: dv/pe/se=%b%b%b p_data=%h cyc=%0d",
                                 DATA_VALID, PAR_ERR, STP_ERR, P_DATA, cyc);
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
                tests++;
                fails++;
                mon_e = exp_q.pop_front();
                $display("FAIL missing_pulse: got no pulse by cyc %0d, required dv/pe/se=%b%b%b p_data=%h at cyc %0d",
                         cyc, mon_e.dv, mon_e.pe, mon_e.se, mon_e.data, mon_e.at);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end else begin
            $display("[TB] check ok: %s = %0h", name, got);
        end
    endtask

    function automatic int pick_prescale();
        int r;
        r = $urandom_range(2, 0);
        return (r == 0) ? 8 : (r == 1) ? 16 : 32;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    // Serialise one frame; nbits > 0 truncates it after that many bits.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                              input logic flip, input logic stopv, input logic glitch,
                              input logic expect_ev, input int nbits);
        logic fb[0:10];
        int   n, lim, gk, t_fall;
        logic good_par, pfail;
        exp_t e;
        good_par = ((($countones(d)) % 2) == 1) ^ ptyp;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        if (pen) begin
            fb[9]  = good_par ^ flip;
            fb[10] = stopv;
            n = 11;
        end else begin
            fb[9]  = stopv;
            fb[10] = 1'b1;
            n = 10;
        end
        lim = (nbits > 0) ? nbits : n;
        for (int i = 0; i < lim; i++) begin
            gk = (glitch && i >= 1 && i <= 8 + int'(pen)) ? int'($urandom_range(p/2 + 1, p/2 - 1)) : -1;
            for (int k = 0; k < p; k++) begin
                @(negedge CLK);
                if (i == 0 && k == 0) begin
                    PRESCALE = 6'(p);
                    PAR_EN   = pen;
                    PAR_TYP  = ptyp;
                    t_fall   = cyc + 1;
                    if (expect_ev) begin
                        pfail  = pen & flip;
                        e.dv   = stopv & ~pfail;
                        e.pe   = pfail;
                        e.se   = ~stopv;
                        if (e.dv) model_pdata = d;
                        e.data = model_pdata;
                        e.at   = t_fall + 3 + (9 + int'(pen)) * p + p / 2 + 1;
                        exp_q.push_back(e);
                    end
                end
                if (i == 2 && k == 0) begin
                    // Inputs wander mid-frame; the latched configuration must hold.
                    PRESCALE = 6'(pick_prescale());
                    PAR_EN   = 1'($urandom_range(1, 0));
                    PAR_TYP  = 1'($urandom_range(1, 0));
                end
                RX_IN = (k == gk) ? ~fb[i] : fb[i];
            end
        end
    endtask

    initial begin
        repeat (90000) @(posedge CLK);
        $display("FAIL watchdog: got no end of test by cyc %0d, required finish", cyc);
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge CLK);
        check("reset_p_data", 32'(P_DATA), 32'h0);
        check("reset_data_valid", 32'(DATA_VALID), 32'h0);
        check("reset_par_err", 32'(PAR_ERR), 32'h0);
        check("reset_stp_err", 32'(STP_ERR), 32'h0);
        RST = 1'b0;
        idle(20);

        // Clean frame, no parity.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        idle(16);

        // Even parity: good, then flipped parity bit.
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        idle(16);

        // Odd parity with stop bit forced low, then also parity flipped.
        send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(32);
        send_frame(8'h01, 32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        idle(32);

        // Short low pulse is rejected as a false start.
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        idle(80);
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        idle(16);

        // Back-to-back frames, clean and with one corrupted sample per bit.
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        idle(16);

        // Reset in the middle of a data field.
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        @(negedge CLK);
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(negedge CLK);
        check("midframe_reset_p_data", 32'(P_DATA), 32'h0);
        check("midframe_reset_flags", {29'h0, DATA_VALID, PAR_ERR, STP_ERR}, 32'h0);
        model_pdata = 8'h00;
        RST = 1'b0;
        idle(20);

        // Break: line held low long after the would-be stop bit.
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        repeat (320) @(negedge CLK);
        idle(16);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        idle(16);

        // Randomised frames against the line-level model.
        for (int f = 0; f < 40; f++) begin
            int   p;
            logic stopv;
            p     = pick_prescale();
            stopv = ($urandom_range(7, 0) != 0);
            send_frame(8'($urandom), p, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       ($urandom_range(5, 0) == 0), stopv, 1'($urandom_range(1, 0)), 1'b1, 0);
            idle(int'($urandom_range(2, 0)) * p + (stopv ? 0 : p));
        end

        idle(200);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
